// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the 16-entry reorder buffer.
//   ROB_SIZE / IDX_W : entry count and tag width.
//   rob_type_e       : entry class recorded at dispatch.
//   ZERO4 / ZERO32   : reset values for tags and data.
//   idx_inc          : circular pointer increment.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W:0]   FULL_COUNT = 5'd16;
    localparam logic [IDX_W-1:0] ZERO4      = 4'd0;
    localparam logic [31:0]      ZERO32     = 32'd0;

    typedef enum logic [1:0] {
        ROB_ALU  = 2'd0,  // register-writing op or load
        ROB_BR   = 2'd1,  // conditional branch
        ROB_ST   = 2'd2,  // store
        ROB_JALR = 2'd3   // indirect jump with link
    } rob_type_e;

    // The pointer width equals log2(ROB_SIZE), so plain overflow wraps the ring.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/reorder_buffer_rob_query.sv
// Operand lookup port of the reorder buffer.
//   q_idx             : tag being looked up
//   entry_valid       : per-entry busy & ready
//   entry_val         : per-entry stored value
//   alu_* / lsb_*     : result buses of the current cycle (forwarded)
//   q_ready / q_val   : lookup result; zero when the value is not available
module reorder_buffer_rob_query
    import reorder_buffer_pkg::*;
(
    input  logic [IDX_W-1:0]    q_idx,
    input  logic [ROB_SIZE-1:0] entry_valid,
    input  logic [31:0]         entry_val [ROB_SIZE],
    input  logic                alu_flag,
    input  logic [31:0]         alu_val,
    input  logic [IDX_W-1:0]    alu_idx,
    input  logic                lsb_flag,
    input  logic [31:0]         lsb_val,
    input  logic [IDX_W-1:0]    lsb_idx,
    output logic                q_ready,
    output logic [31:0]         q_val
);

    // Bus results of this cycle take precedence (ALU before LSB) over stored values.
    always_comb begin
        q_ready = 1'b0;
        q_val   = ZERO32;
        if (alu_flag && (alu_idx == q_idx)) begin
            q_ready = 1'b1;
            q_val   = alu_val;
        end else if (lsb_flag && (lsb_idx == q_idx)) begin
            q_ready = 1'b1;
            q_val   = lsb_val;
        end else if (entry_valid[q_idx]) begin
            q_ready = 1'b1;
            q_val   = entry_val[q_idx];
        end else begin
            q_ready = 1'b0;
            q_val   = ZERO32;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates tags at dispatch, captures
// ALU/LSB results, and retires entries in program order.
//   clk, rst (sync, active low), rdy (global enable)
//   dec_*          : dispatch request and entry contents
//   rob_full, rob_alloc_idx : allocation status / tag of this cycle's dispatch
//   alu_*, LSB_*   : result buses
//   q1_*, q2_*     : combinational operand lookups
//   commit_*, jump_wrong, jump_pc : registered retirement outputs
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             dec_flag_in,
    input  logic [1:0]       dec_type,
    input  logic [4:0]       dec_rd,
    input  logic             dec_ready_in,
    input  logic [31:0]      dec_val_in,
    input  logic             dec_pred_jump,
    input  logic [31:0]      dec_alt_pc,
    output logic             rob_full,
    output logic [IDX_W-1:0] rob_alloc_idx,
    input  logic             alu_flag_in,
    input  logic [31:0]      alu_val_in,
    input  logic [IDX_W-1:0] alu_to_ROB_in,
    input  logic             LSB_flag_in,
    input  logic [31:0]      LSB_val_in,
    input  logic [IDX_W-1:0] LSB_to_ROB_in,
    input  logic [IDX_W-1:0] q1_idx,
    input  logic [IDX_W-1:0] q2_idx,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,
    output logic             commit_flag,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [IDX_W-1:0] commit_idx,
    output logic             commit_store,
    output logic             jump_wrong,
    output logic [31:0]      jump_pc
);

    logic [ROB_SIZE-1:0] busy_r;
    logic [ROB_SIZE-1:0] ready_r;
    logic [ROB_SIZE-1:0] pred_r;
    rob_type_e           type_r   [ROB_SIZE];
    logic [4:0]          rd_r     [ROB_SIZE];
    logic [31:0]         val_r    [ROB_SIZE];
    logic [31:0]         alt_pc_r [ROB_SIZE];
    logic [IDX_W-1:0]    head_r;
    logic [IDX_W-1:0]    tail_r;
    logic [IDX_W:0]      count_r;

    logic                dispatch_s;
    logic                retire_s;
    logic [ROB_SIZE-1:0] wb_en_s;
    logic [31:0]         wb_val_s [ROB_SIZE];
    logic [ROB_SIZE-1:0] entry_valid_s;

    assign rob_full      = (count_r == FULL_COUNT);
    assign rob_alloc_idx = tail_r;
    assign entry_valid_s = busy_r & ready_r;

    // Dispatch only against the registered full flag; retire only an already-ready head.
    always_comb begin
        dispatch_s = 1'b0;
        retire_s   = 1'b0;
        if (dec_flag_in && !rob_full) begin
            dispatch_s = 1'b1;
        end else begin
            dispatch_s = 1'b0;
        end
        if (busy_r[head_r] && ready_r[head_r]) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Per-entry result capture: only waiting entries accept a bus; ALU wins a shared tag.
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            wb_en_s[i]  = 1'b0;
            wb_val_s[i] = ZERO32;
            if (busy_r[i] && !ready_r[i]) begin
                if (alu_flag_in && (alu_to_ROB_in == IDX_W'(i))) begin
                    wb_en_s[i]  = 1'b1;
                    wb_val_s[i] = alu_val_in;
                end else if (LSB_flag_in && (LSB_to_ROB_in == IDX_W'(i))) begin
                    wb_en_s[i]  = 1'b1;
                    wb_val_s[i] = LSB_val_in;
                end else begin
                    wb_en_s[i]  = 1'b0;
                    wb_val_s[i] = ZERO32;
                end
            end else begin
                wb_en_s[i]  = 1'b0;
                wb_val_s[i] = ZERO32;
            end
        end
    end

    // Entry state, pointers and registered retirement outputs.
    always_ff @(posedge clk) begin
        if (!rst || jump_wrong) begin
            // A committed redirect empties the buffer exactly like reset.
            busy_r       <= '0;
            ready_r      <= '0;
            head_r       <= ZERO4;
            tail_r       <= ZERO4;
            count_r      <= 5'd0;
            commit_flag  <= 1'b0;
            commit_rd    <= 5'd0;
            commit_val   <= ZERO32;
            commit_idx   <= ZERO4;
            commit_store <= 1'b0;
            jump_wrong   <= 1'b0;
            jump_pc      <= ZERO32;
        end else if (!rdy) begin
            commit_flag  <= 1'b0;
            commit_store <= 1'b0;
            jump_wrong   <= 1'b0;
        end else begin
            commit_flag  <= 1'b0;
            commit_store <= 1'b0;
            jump_wrong   <= 1'b0;

            for (int i = 0; i < ROB_SIZE; i++) begin
                if (wb_en_s[i]) begin
                    ready_r[i] <= 1'b1;
                    // JALR keeps its link value; the bus carries the jump target.
                    if (type_r[i] == ROB_JALR) begin
                        alt_pc_r[i] <= wb_val_s[i];
                    end else begin
                        val_r[i] <= wb_val_s[i];
                    end
                end
            end

            if (retire_s) begin
                busy_r[head_r] <= 1'b0;
                head_r         <= idx_inc(head_r);
                commit_idx     <= head_r;
                commit_rd      <= rd_r[head_r];
                commit_val     <= val_r[head_r];
                case (type_r[head_r])
                    ROB_ALU: begin
                        commit_flag <= 1'b1;
                    end
                    ROB_ST: begin
                        commit_store <= 1'b1;
                    end
                    ROB_BR: begin
                        // Outcome bit 0 is the resolved direction.
                        if (val_r[head_r][0] != pred_r[head_r]) begin
                            jump_wrong <= 1'b1;
                            jump_pc    <= alt_pc_r[head_r];
                        end
                    end
                    ROB_JALR: begin
                        commit_flag <= 1'b1;
                        jump_wrong  <= 1'b1;
                        jump_pc     <= alt_pc_r[head_r];
                    end
                    default: begin
                        commit_flag <= 1'b0;
                    end
                endcase
            end

            if (dispatch_s) begin
                busy_r[tail_r]   <= 1'b1;
                ready_r[tail_r]  <= dec_ready_in;
                type_r[tail_r]   <= rob_type_e'(dec_type);
                rd_r[tail_r]     <= dec_rd;
                val_r[tail_r]    <= dec_val_in;
                pred_r[tail_r]   <= dec_pred_jump;
                alt_pc_r[tail_r] <= dec_alt_pc;
                tail_r           <= idx_inc(tail_r);
            end

            case ({dispatch_s, retire_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    reorder_buffer_rob_query u_query1 (
        .q_idx       (q1_idx),
        .entry_valid (entry_valid_s),
        .entry_val   (val_r),
        .alu_flag    (alu_flag_in),
        .alu_val     (alu_val_in),
        .alu_idx     (alu_to_ROB_in),
        .lsb_flag    (LSB_flag_in),
        .lsb_val     (LSB_val_in),
        .lsb_idx     (LSB_to_ROB_in),
        .q_ready     (q1_ready),
        .q_val       (q1_val)
    );

    reorder_buffer_rob_query u_query2 (
        .q_idx       (q2_idx),
        .entry_valid (entry_valid_s),
        .entry_val   (val_r),
        .alu_flag    (alu_flag_in),
        .alu_val     (alu_val_in),
        .alu_idx     (alu_to_ROB_in),
        .lsb_flag    (LSB_flag_in),
        .lsb_val     (LSB_val_in),
        .lsb_idx     (LSB_to_ROB_in),
        .q_ready     (q2_ready),
        .q_val       (q2_val)
    );

endmodule
